// File: rtl/ex_stage_pkg.sv
// ============================================================================
// ex_stage_pkg : shared ALU opcodes, forwarding selects, muldiv FSM states
// Rev 1.0
// ============================================================================
`ifndef R_WIDTH
`define R_WIDTH 5
`endif
`default_nettype none

package ex_stage_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_MULTU = 4'd10;
  localparam logic [3:0] ALU_DIVU  = 4'd11;
  localparam logic [3:0] ALU_MFHI  = 4'd12;
  localparam logic [3:0] ALU_MFLO  = 4'd13;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  // Code 11 is unused by the forwarding unit and falls back to the register value.
  function automatic logic [31:0] fwd_select(input logic [1:0]  sel,
                                             input logic [31:0] reg_v,
                                             input logic [31:0] wb_v,
                                             input logic [31:0] mem_v);
    case (sel)
      FWD_WB:  return wb_v;
      FWD_MEM: return mem_v;
      default: return reg_v;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv.sv
// ============================================================================
// ex_muldiv : 32-cycle iterative MULTU (shift-add) / DIVU (restoring) with HI/LO
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_muldiv
  import ex_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        is_div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q;
  logic        is_div_q;
  logic [31:0] opnd_q, work_hi_q, work_lo_q, hi_q, lo_q;
  logic [32:0] mul_sum_w, div_shift_w;
  logic        div_ge_w;
  logic [31:0] step_hi_w, step_lo_w;

  // A zero divisor needs no special case: every trial subtract succeeds, giving
  // an all-ones quotient and the dividend left over as remainder.
  always_comb begin
    mul_sum_w   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift_w = {work_hi_q, work_lo_q[31]};
    div_ge_w    = div_shift_w >= {1'b0, opnd_q};
    if (is_div_q) begin
      step_hi_w = div_ge_w ? 32'(div_shift_w - {1'b0, opnd_q}) : div_shift_w[31:0];
      step_lo_w = {work_lo_q[30:0], div_ge_w};
    end else begin
      step_hi_w = mul_sum_w[32:1];
      step_lo_w = {mul_sum_w[0], work_lo_q[31:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start_i) state_d = MD_BUSY;
      MD_BUSY: if (count_q == 5'd31) state_d = MD_DONE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= MD_IDLE;
      count_q   <= 5'd0;
      is_div_q  <= 1'b0;
      opnd_q    <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            is_div_q  <= is_div_i;
            count_q   <= 5'd0;
            work_hi_q <= 32'd0;
            opnd_q    <= is_div_i ? b_i : a_i;
            work_lo_q <= is_div_i ? a_i : b_i;
          end
        end
        MD_BUSY: begin
          count_q   <= count_q + 5'd1;
          work_hi_q <= step_hi_w;
          work_lo_q <= step_lo_w;
          if (count_q == 5'd31) begin
            hi_q <= step_hi_w;
            lo_q <= step_lo_w;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_BUSY);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : EX stage with operand forwarding, ALU and EX/MEM pipeline register
// Optional iterative multiply/divide (HI/LO, stall) enabled by MULDIV_EN. Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           fwd_a_i,
  input  logic [1:0]           fwd_b_i,
  input  logic [31:0]          rs_data_i,
  input  logic [31:0]          rt_data_i,
  input  logic [31:0]          imm_i,
  input  logic [31:0]          mem_fwd_data_i,
  input  logic [31:0]          wb_fwd_data_i,
  input  logic [3:0]           alu_op_i,
  input  logic                 alu_src_i,
  input  logic [`R_WIDTH-1:0]  rd_i,
  input  logic                 reg_write_i,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic                 valid_i,
  output logic [31:0]          mem_result_o,
  output logic [31:0]          mem_store_data_o,
  output logic [`R_WIDTH-1:0]  mem_rd_o,
  output logic                 mem_reg_write_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 mem_valid_o,
  output logic                 stall_o
);

  logic [31:0] op_a_w, fwd_b_w, op_b_w, alu_res_w, hi_w, lo_w;
  logic        is_muldiv_w, reg_write_w, bubble_w;

  assign op_a_w      = fwd_select(fwd_a_i, rs_data_i, wb_fwd_data_i, mem_fwd_data_i);
  assign fwd_b_w     = fwd_select(fwd_b_i, rt_data_i, wb_fwd_data_i, mem_fwd_data_i);
  assign op_b_w      = alu_src_i ? imm_i : fwd_b_w;
  assign is_muldiv_w = (alu_op_i == ALU_MULTU) || (alu_op_i == ALU_DIVU);

`ifdef MULDIV_EN
  ex_muldiv u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (valid_i && is_muldiv_w),
    .is_div_i (alu_op_i == ALU_DIVU),
    .a_i      (op_a_w),
    .b_i      (op_b_w),
    .stall_o  (stall_o),
    .hi_o     (hi_w),
    .lo_o     (lo_w)
  );
  // MULTU/DIVU retire only into HI/LO, never into the register file.
  assign reg_write_w = reg_write_i && !is_muldiv_w;
`else
  logic is_mf_w;
  assign is_mf_w     = (alu_op_i == ALU_MFHI) || (alu_op_i == ALU_MFLO);
  assign stall_o     = 1'b0;
  assign hi_w        = 32'd0;
  assign lo_w        = 32'd0;
  assign reg_write_w = reg_write_i && !(is_muldiv_w || is_mf_w);
`endif

  always_comb begin
    alu_res_w = 32'd0;
    case (alu_op_i)
      ALU_ADD:  alu_res_w = op_a_w + op_b_w;
      ALU_SUB:  alu_res_w = op_a_w - op_b_w;
      ALU_AND:  alu_res_w = op_a_w & op_b_w;
      ALU_OR:   alu_res_w = op_a_w | op_b_w;
      ALU_XOR:  alu_res_w = op_a_w ^ op_b_w;
      ALU_NOR:  alu_res_w = ~(op_a_w | op_b_w);
      ALU_SLT:  alu_res_w = {31'd0, $signed(op_a_w) < $signed(op_b_w)};
      ALU_SLTU: alu_res_w = {31'd0, op_a_w < op_b_w};
      ALU_SLL:  alu_res_w = op_b_w << op_a_w[4:0];
      ALU_SRL:  alu_res_w = op_b_w >> op_a_w[4:0];
      ALU_MFHI: alu_res_w = hi_w;
      ALU_MFLO: alu_res_w = lo_w;
      default:  alu_res_w = 32'd0;
    endcase
  end

  assign bubble_w = !valid_i || stall_o;

  logic [31:0]         mem_result_q, mem_store_data_q;
  logic [`R_WIDTH-1:0] mem_rd_q;
  logic                mem_reg_write_q, mem_read_q, mem_write_q, mem_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || bubble_w) begin
      mem_result_q     <= 32'd0;
      mem_store_data_q <= 32'd0;
      mem_rd_q         <= '0;
      mem_reg_write_q  <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_valid_q      <= 1'b0;
    end else begin
      mem_result_q     <= alu_res_w;
      mem_store_data_q <= fwd_b_w;
      mem_rd_q         <= rd_i;
      mem_reg_write_q  <= reg_write_w;
      mem_read_q       <= mem_read_i;
      mem_write_q      <= mem_write_i;
      mem_valid_q      <= 1'b1;
    end
  end

  assign mem_result_o     = mem_result_q;
  assign mem_store_data_o = mem_store_data_q;
  assign mem_rd_o         = mem_rd_q;
  assign mem_reg_write_o  = mem_reg_write_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;
  assign mem_valid_o      = mem_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : scoreboard bench for ex_stage (muldiv cases under MULDIV_EN)
// Rev 1.0
// ============================================================================
`ifndef R_WIDTH
`define R_WIDTH 5
`endif
`default_nettype none

module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam int RW = `R_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    fwd_a_i, fwd_b_i;
  logic [31:0]   rs_data_i, rt_data_i, imm_i, mem_fwd_data_i, wb_fwd_data_i;
  logic [3:0]    alu_op_i;
  logic          alu_src_i;
  logic [RW-1:0] rd_i;
  logic          reg_write_i, mem_read_i, mem_write_i, valid_i;
  logic [31:0]   mem_result_o, mem_store_data_o;
  logic [RW-1:0] mem_rd_o;
  logic          mem_reg_write_o, mem_read_o, mem_write_o, mem_valid_o, stall_o;

  ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .mem_fwd_data_i(mem_fwd_data_i), .wb_fwd_data_i(wb_fwd_data_i),
    .alu_op_i(alu_op_i), .alu_src_i(alu_src_i), .rd_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .valid_i(valid_i), .mem_result_o(mem_result_o), .mem_store_data_o(mem_store_data_o),
    .mem_rd_o(mem_rd_o), .mem_reg_write_o(mem_reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_valid_o(mem_valid_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string         nm;
    logic [31:0]   res;
    logic [31:0]   st;
    logic [RW-1:0] rd;
    logic          rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && mem_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.nm, "_result"}, 64'(mem_result_o), 64'(mon_e.res));
        check({mon_e.nm, "_store"}, 64'(mem_store_data_o), 64'(mon_e.st));
        check({mon_e.nm, "_ctrl"}, 64'({mem_rd_o, mem_reg_write_o, mem_read_o, mem_write_o}),
              64'({mon_e.rd, mon_e.rw, mon_e.mr, mon_e.mw}));
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG;
    rs_data_i = 0; rt_data_i = 0; imm_i = 0; mem_fwd_data_i = 0; wb_fwd_data_i = 0;
    alu_op_i = ALU_ADD; alu_src_i = 0; rd_i = '0;
    reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; valid_i = 0;
  endtask

  task automatic send(input string nm, input logic [31:0] res, input logic [31:0] st,
                      input logic rw);
    sb.push_back('{nm, res, st, rd_i, rw, mem_read_i, mem_write_i});
    step();
  endtask

  task automatic alu(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res);
    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; alu_src_i = 0;
    rs_data_i = a; rt_data_i = b; alu_op_i = op; rd_i = RW'(op) + RW'(1);
    reg_write_i = 1; mem_read_i = 0; mem_write_i = 0; valid_i = 1;
    send(nm, res, b, 1'b1);
  endtask

  task automatic mf(input string nm, input logic [3:0] op, input logic [31:0] res,
                    input logic rw);
    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; alu_src_i = 0;
    rs_data_i = 0; rt_data_i = 0; alu_op_i = op; rd_i = RW'(9);
    reg_write_i = 1; mem_read_i = 0; mem_write_i = 0; valid_i = 1;
    send(nm, res, 32'd0, rw);
  endtask

`ifdef MULDIV_EN
  task automatic muldiv(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; alu_src_i = 0;
    rs_data_i = a; rt_data_i = b; alu_op_i = op; rd_i = RW'(2);
    reg_write_i = 1; mem_read_i = 0; mem_write_i = 0; valid_i = 1;
    sb.push_back('{nm, 32'd0, b, rd_i, 1'b0, 1'b0, 1'b0});
    #1;
    n = (stall_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      if (stall_o !== 1'b1) break;
      step();
      if (stall_o === 1'b1) n++;
    end
    check({nm, "_stall_cycles"}, 64'(n), 64'd33);
    step();
  endtask
`endif

  initial begin
    set_idle();
    rst_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_data", {mem_result_o, mem_store_data_o}, 64'd0);
    check("reset_ctrl", 64'({mem_rd_o, mem_reg_write_o, mem_read_o, mem_write_o,
                             mem_valid_o, stall_o}), 64'd0);
    rst_i = 0;
    step();

    valid_i = 1; alu_op_i = ALU_ADD; fwd_a_i = FWD_MEM; mem_fwd_data_i = 5; rs_data_i = 1;
    fwd_b_i = FWD_REG; rt_data_i = 3; alu_src_i = 0; rd_i = RW'(3); reg_write_i = 1;
    send("fwd_mem_add", 32'd8, 32'd3, 1'b1);

    fwd_a_i = FWD_REG; rs_data_i = 10; fwd_b_i = FWD_WB; wb_fwd_data_i = 7; rt_data_i = 99;
    alu_src_i = 1; imm_i = 2; reg_write_i = 0; mem_write_i = 1; rd_i = '0;
    send("sw_fwd_wb", 32'd12, 32'd7, 1'b0);

    fwd_a_i = 2'b11; rs_data_i = 20; mem_fwd_data_i = 1; wb_fwd_data_i = 2;
    fwd_b_i = FWD_REG; rt_data_i = 5; alu_src_i = 0; alu_op_i = ALU_SUB;
    reg_write_i = 1; mem_write_i = 0; rd_i = RW'(4);
    send("fwd11_sub", 32'd15, 32'd5, 1'b1);

    alu("and",    ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
    alu("or",     ALU_OR,   32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    alu("xor",    ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    alu("nor",    ALU_NOR,  32'hFFFF_0000, 32'h0000_00FF, 32'h0000_FF00);
    alu("slt",    ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1);
    alu("sltu",   ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu("sll",    ALU_SLL,  32'd36,        32'd3,         32'd48);
    alu("srl",    ALU_SRL,  32'd4,         32'h100,       32'h10);
    alu("addwrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu("subwrap", ALU_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF);
    alu("op14",   4'd14,    32'd7,         32'd9,         32'd0);

    valid_i = 0; alu_op_i = ALU_ADD; rs_data_i = 5; rt_data_i = 6;
    reg_write_i = 1; mem_read_i = 1; rd_i = RW'(7);
    step();
    check("bubble_ctrl", 64'({mem_valid_o, mem_reg_write_o, mem_read_o, mem_write_o, mem_rd_o}),
          64'd0);
    check("bubble_data", {mem_result_o, mem_store_data_o}, 64'd0);
    mem_read_i = 0;

`ifdef MULDIV_EN
    muldiv("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2);
    mf("mfhi_mul", ALU_MFHI, 32'd1, 1'b1);
    mf("mflo_mul", ALU_MFLO, 32'hFFFF_FFFE, 1'b1);
    muldiv("divu_by0", ALU_DIVU, 32'd100, 32'd0);
    mf("mflo_div0", ALU_MFLO, 32'hFFFF_FFFF, 1'b1);
    mf("mfhi_div0", ALU_MFHI, 32'd100, 1'b1);
    muldiv("divu_by7", ALU_DIVU, 32'd100, 32'd7);
    mf("mflo_div7", ALU_MFLO, 32'd14, 1'b1);
    mf("mfhi_div7", ALU_MFHI, 32'd2, 1'b1);

    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; rs_data_i = 3; rt_data_i = 4;
    alu_op_i = ALU_MULTU; reg_write_i = 1; valid_i = 1;
    #1;
    check("abort_stall_start", 64'(stall_o), 64'd1);
    repeat (10) step();
    rst_i = 1;
    valid_i = 0;
    #1;
    check("abort_stall_cleared", 64'(stall_o), 64'd0);
    check("abort_outputs", 64'({mem_valid_o, mem_reg_write_o, mem_read_o, mem_write_o,
                                mem_rd_o, mem_result_o}), 64'd0);
    rst_i = 0;
    sb.delete();
    mf("mflo_after_abort", ALU_MFLO, 32'd0, 1'b1);
    mf("mfhi_after_abort", ALU_MFHI, 32'd0, 1'b1);
`else
    fwd_a_i = FWD_REG; fwd_b_i = FWD_REG; rs_data_i = 3; rt_data_i = 4;
    alu_op_i = ALU_MULTU; reg_write_i = 1; valid_i = 1; rd_i = RW'(2);
    #1;
    check("multu_off_stall", 64'(stall_o), 64'd0);
    send("multu_off", 32'd0, 32'd4, 1'b0);
    mf("mfhi_off", ALU_MFHI, 32'd0, 1'b0);
    mf("mflo_off", ALU_MFLO, 32'd0, 1'b0);
`endif

    set_idle();
    repeat (3) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
